// File: rtl/heartbeat_rate_meter.sv
// Heartbeat rate meter.
// Synchronises a raw beat pulse, detects rising edges, rejects bounce with a
// refractory interval, counts accepted beats over a fixed window and keeps a
// moving average of the last 2^AVG_LOG2 window counts.
module heartbeat_rate_meter #(
    parameter int CNT_W          = 8,
    parameter int WIN_CYCLES     = 1000,
    parameter int SYNC_STAGES    = 2,
    parameter int REFRACT_CYCLES = 50,
    parameter int AVG_LOG2       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pulse_in,
    output logic             beat_strobe,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    output logic             overflow,
    output logic [CNT_W-1:0] avg_out,
    output logic             avg_valid
);

    localparam int WIN_W  = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
    localparam int REFR_W = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;
    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int SUM_W  = CNT_W + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;

    // Synchroniser and edge detector state
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;

    // Measurement state
    logic [WIN_W-1:0]  win_cnt_q,   win_cnt_d;
    logic [REFR_W-1:0] refr_cnt_q,  refr_cnt_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic              ovf_pend_q,  ovf_pend_d;
    logic              beat_q,      beat_d;
    logic [CNT_W-1:0]  rate_q,      rate_d;
    logic              rate_vld_q,  rate_vld_d;
    logic              ovf_q,       ovf_d;

    // Moving-average state
    logic [CNT_W-1:0]  hist_q [DEPTH];
    logic [SUM_W-1:0]  sum_q,       sum_d;
    logic [AVG_LOG2-1:0] wr_ptr_q,  wr_ptr_d;
    logic [FILL_W-1:0] fill_q,      fill_d;
    logic [CNT_W-1:0]  avg_q,       avg_d;
    logic              avg_vld_q,   avg_vld_d;

    // Decoded per-cycle events
    logic             edge_det;
    logic             accept;
    logic             terminal;
    logic             cnt_max;
    logic             inc;
    logic             sat_hit;
    logic [CNT_W-1:0] cnt_plus;

    // Shift the raw pulse through the synchroniser and remember the previous synced level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Decode edge acceptance, terminal cycle and saturating increment
    always_comb begin
        edge_det = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
        accept   = enable & edge_det & (refr_cnt_q == '0);
        terminal = enable & (win_cnt_q == WIN_W'(WIN_CYCLES - 1));
        cnt_max  = (count_q == '1);
        inc      = accept & ~cnt_max;
        sat_hit  = accept & cnt_max;
        cnt_plus = count_q + CNT_W'(inc);
    end

    // Next state for window, refractory, beat count and published rate
    always_comb begin
        win_cnt_d  = '0;
        refr_cnt_d = '0;
        count_d    = '0;
        ovf_pend_d = 1'b0;
        beat_d     = accept;
        rate_vld_d = terminal;
        rate_d     = rate_q;
        ovf_d      = ovf_q;
        if (enable) begin
            win_cnt_d = terminal ? '0 : win_cnt_q + WIN_W'(1);
            if (accept) begin
                refr_cnt_d = REFR_W'(REFRACT_CYCLES);
            end else if (refr_cnt_q != '0) begin
                refr_cnt_d = refr_cnt_q - REFR_W'(1);
            end
            if (terminal) begin
                // A beat on the terminal cycle still belongs to the closing window
                rate_d = cnt_plus;
                ovf_d  = ovf_pend_q | sat_hit;
            end else begin
                count_d    = cnt_plus;
                ovf_pend_d = ovf_pend_q | sat_hit;
            end
        end
    end

    // Next state for the running sum, history pointer, fill level and average
    always_comb begin
        sum_d     = sum_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        avg_d     = avg_q;
        avg_vld_d = 1'b0;
        if (rate_vld_q) begin
            sum_d     = sum_q + SUM_W'(rate_q) - SUM_W'(hist_q[wr_ptr_q]);
            wr_ptr_d  = wr_ptr_q + AVG_LOG2'(1);
            fill_d    = (fill_q == FILL_W'(DEPTH)) ? fill_q : fill_q + FILL_W'(1);
            avg_d     = sum_d[SUM_W-1:AVG_LOG2];
            avg_vld_d = (fill_d == FILL_W'(DEPTH));
        end
    end

    // Register measurement and averaging state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt_q  <= '0;
            refr_cnt_q <= '0;
            count_q    <= '0;
            ovf_pend_q <= 1'b0;
            beat_q     <= 1'b0;
            rate_q     <= '0;
            rate_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            sum_q      <= '0;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            avg_q      <= '0;
            avg_vld_q  <= 1'b0;
        end else begin
            win_cnt_q  <= win_cnt_d;
            refr_cnt_q <= refr_cnt_d;
            count_q    <= count_d;
            ovf_pend_q <= ovf_pend_d;
            beat_q     <= beat_d;
            rate_q     <= rate_d;
            rate_vld_q <= rate_vld_d;
            ovf_q      <= ovf_d;
            sum_q      <= sum_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            avg_q      <= avg_d;
            avg_vld_q  <= avg_vld_d;
        end
    end

    // History of published window counts, overwritten oldest-first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else if (rate_vld_q) begin
            hist_q[wr_ptr_q] <= rate_q;
        end
    end

    assign beat_strobe = beat_q;
    assign rate_out    = rate_q;
    assign rate_valid  = rate_vld_q;
    assign overflow    = ovf_q;
    assign avg_out     = avg_q;
    assign avg_valid   = avg_vld_q;

endmodule

// File: tb/tb_heartbeat_rate_meter.sv
// Directed bench for heartbeat_rate_meter: one instance with a 100-cycle window
// and a second with a 200-cycle window for the saturation case.
module tb_heartbeat_rate_meter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       en2 = 1'b0;
    logic       pulse_in = 1'b0;

    logic       beat_strobe, rate_valid, overflow, avg_valid;
    logic [3:0] rate_out, avg_out;
    logic       beat_strobe2, rate_valid2, overflow2, avg_valid2;
    logic [3:0] rate_out2, avg_out2;

    int n_checks = 0;
    int n_pass   = 0;
    int strobes  = 0;
    int rv_seen  = 0;
    bit rv_prev  = 0;
    bit av_prev  = 0;
    bit rv_double = 0;
    bit av_double = 0;

    heartbeat_rate_meter #(
        .CNT_W(4), .WIN_CYCLES(100), .SYNC_STAGES(2), .REFRACT_CYCLES(5), .AVG_LOG2(2)
    ) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .pulse_in(pulse_in),
        .beat_strobe(beat_strobe), .rate_out(rate_out), .rate_valid(rate_valid),
        .overflow(overflow), .avg_out(avg_out), .avg_valid(avg_valid)
    );

    heartbeat_rate_meter #(
        .CNT_W(4), .WIN_CYCLES(200), .SYNC_STAGES(2), .REFRACT_CYCLES(5), .AVG_LOG2(2)
    ) u_dut2 (
        .clk(clk), .reset(reset), .enable(en2), .pulse_in(pulse_in),
        .beat_strobe(beat_strobe2), .rate_out(rate_out2), .rate_valid(rate_valid2),
        .overflow(overflow2), .avg_out(avg_out2), .avg_valid(avg_valid2)
    );

    always #5 clk = ~clk;

    // Observe the first instance mid-cycle: count strobes and valids, flag back-to-back valids
    always @(negedge clk) begin
        if (beat_strobe) strobes = strobes + 1;
        if (rate_valid) rv_seen = rv_seen + 1;
        if (rate_valid && rv_prev) rv_double = 1;
        if (avg_valid && av_prev) av_double = 1;
        rv_prev = rate_valid;
        av_prev = avg_valid;
    end

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("check %-16s got %0d expected %0d ok", tag, obs, exp);
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pulses(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            pulse_in = 1'b1;
            tick(3);
            pulse_in = 1'b0;
            tick(gap - 3);
        end
    endtask

    // Waits for rate_valid of instance 1 or 2; n returns the cycles spent
    task automatic wait_rv(input int which, input int budget, output int n);
        bit got;
        got = 0;
        n = 0;
        while (!got && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if ((which == 1 && rate_valid) || (which == 2 && rate_valid2)) got = 1;
        end
        check_val("rv_arrived", got, 1);
    endtask

    int n, s0, r0;

    initial begin
        // Reset state
        #2 reset = 1'b1;
        tick(3);
        check_val("rst_rate", rate_out, 0);
        check_val("rst_rvalid", rate_valid, 0);
        check_val("rst_ovf", overflow, 0);
        check_val("rst_avg", avg_out, 0);
        check_val("rst_avalid", avg_valid, 0);
        check_val("rst_strobe", beat_strobe, 0);
        enable = 1'b1;
        reset  = 1'b0;               // this cycle is window cycle 0

        // Seven clean pulses, 12 cycles apart
        tick(5);
        s0 = strobes;
        send_pulses(7, 12);
        check_val("clean_strobes", strobes - s0, 7);
        wait_rv(1, 150, n);
        check_val("clean_rate", rate_out, 7);
        check_val("clean_ovf", overflow, 0);
        tick(1);
        check_val("rv_one_cycle", rate_valid, 0);

        // Bounce: edges at t, t+2, t+4 then clean edge at t+20
        tick(1);
        s0 = strobes;
        pulse_in = 1; tick(1); pulse_in = 0; tick(1);
        pulse_in = 1; tick(1); pulse_in = 0; tick(1);
        pulse_in = 1; tick(1); pulse_in = 0; tick(15);
        pulse_in = 1; tick(3); pulse_in = 0; tick(5);
        check_val("bounce_strobes", strobes - s0, 2);
        // Edges at t and t+6: second one accepted
        s0 = strobes;
        pulse_in = 1; tick(1); pulse_in = 0; tick(5);
        pulse_in = 1; tick(1); pulse_in = 0; tick(8);
        check_val("refr_t6", strobes - s0, 2);
        // Edges at t and t+5: second one rejected
        s0 = strobes;
        pulse_in = 1; tick(1); pulse_in = 0; tick(4);
        pulse_in = 1; tick(1); pulse_in = 0; tick(9);
        check_val("refr_t5", strobes - s0, 1);
        wait_rv(1, 150, n);
        check_val("bounce_rate", rate_out, 5);

        // Reset mid-window clears outputs at once
        tick(10);
        reset = 1'b1;
        #1;
        check_val("async_rate", rate_out, 0);
        check_val("async_avg", avg_out, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;                // window cycle 0

        // Averaging: windows of 4, 8, 4, 8, 0 beats
        send_pulses(4, 10);
        wait_rv(1, 150, n);
        check_val("reset_win_len", 40 + n, 100);
        check_val("w1_rate", rate_out, 4);
        tick(1);
        check_val("w1_avalid", avg_valid, 0);
        check_val("w1_avg", avg_out, 1);
        send_pulses(8, 10);
        wait_rv(1, 150, n);
        check_val("w2_rate", rate_out, 8);
        tick(1);
        check_val("w2_avalid", avg_valid, 0);
        check_val("w2_avg", avg_out, 3);
        send_pulses(4, 10);
        wait_rv(1, 150, n);
        check_val("w3_rate", rate_out, 4);
        tick(1);
        check_val("w3_avalid", avg_valid, 0);
        check_val("w3_avg", avg_out, 4);
        send_pulses(8, 10);
        wait_rv(1, 150, n);
        check_val("w4_rate", rate_out, 8);
        tick(1);
        check_val("w4_avalid", avg_valid, 1);
        check_val("w4_avg", avg_out, 6);
        wait_rv(1, 150, n);
        check_val("w5_rate", rate_out, 0);
        tick(1);
        check_val("w5_avalid", avg_valid, 1);
        check_val("w5_avg", avg_out, 5);

        // Disable for 150 cycles after 3 beats
        send_pulses(3, 10);
        enable = 1'b0;
        s0 = strobes;
        r0 = rv_seen;
        send_pulses(2, 10);
        tick(130);
        check_val("dis_no_rv", rv_seen - r0, 0);
        check_val("dis_no_strobe", strobes - s0, 0);
        check_val("dis_avg_held", avg_out, 5);
        check_val("dis_rate_held", rate_out, 0);
        enable = 1'b1;               // fresh window cycle 0
        send_pulses(1, 10);
        tick(87);
        pulse_in = 1'b1;             // accepted exactly on the terminal cycle
        wait_rv(1, 10, n);
        pulse_in = 1'b0;
        check_val("reen_win_len", 97 + n, 100);
        check_val("term_beat_rate", rate_out, 2);
        tick(1);
        check_val("reen_rv_one", rate_valid, 0);

        // Saturation on the 200-cycle instance
        enable = 1'b0;
        tick(5);
        en2 = 1'b1;
        send_pulses(20, 8);
        wait_rv(2, 100, n);
        check_val("sat_rate", rate_out2, 15);
        check_val("sat_ovf", overflow2, 1);
        tick(1);
        send_pulses(3, 10);
        wait_rv(2, 250, n);
        check_val("post_sat_rate", rate_out2, 3);
        check_val("post_sat_ovf", overflow2, 0);

        check_val("rv_never_double", rv_double, 0);
        check_val("av_never_double", av_double, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
